reg_scoreboard: RTL and testbench

//  Multi-port counting register-lock scoreboard, successor to the single-port lock bitmap. Tracks

---
 rtl/reg_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_reg_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: counting register-lock scoreboard.
// Each architectural register holds a saturating count of outstanding writers.
// Issue ports raise the count, writeback ports lower it, and query ports report
// whether a register still has at least one writer in flight.
module reg_scoreboard #(
  parameter int XWDT = 6,
  parameter int XN   = 64,
  parameter int NSET = 2,
  parameter int NCLR = 2,
  parameter int NQ   = 3,
  parameter int CNTW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSET-1:0]      set_valid,
  input  logic [NSET*XWDT-1:0] set_addr,
  output logic [NSET-1:0]      set_ready,
  input  logic [NCLR-1:0]      clr_valid,
  input  logic [NCLR*XWDT-1:0] clr_addr,
  input  logic                 flush,
  input  logic [NQ*XWDT-1:0]   q_addr,
  output logic [NQ-1:0]        q_busy,
  output logic [XN-1:0]        rlocks,
  output logic                 err_ovf,
  output logic                 err_unf
);

  // Sum width covers a saturated count plus every port hitting one register.
  localparam int SW = CNTW + $clog2(NSET + NCLR + 1) + 1;
  localparam logic [SW-1:0] CMAX = SW'((2 ** CNTW) - 1);

  logic [CNTW-1:0] cnt_r     [XN];
  logic [CNTW-1:0] cnt_nxt_s [XN];
  logic [XN-1:0]   rlocks_r;
  logic            err_ovf_r;
  logic            err_unf_r;
  logic [NSET-1:0] set_ready_s;
  logic [NSET-1:0] set_acc_s;
  logic [NSET-1:0] set_ovf_s;
  logic            ovf_evt_s;
  logic            unf_evt_s;
  logic [NQ-1:0]   q_busy_s;

  // Register 0 and addresses past the tracked range are never locked.
  function automatic logic in_range(input logic [XWDT-1:0] a);
    in_range = (a != {XWDT{1'b0}}) && (int'(a) < XN);
  endfunction

  // Set acceptance: a set is refused when its register plus lower-index
  // same-cycle sets would exceed the counter's maximum.
  always_comb begin : set_rule_p
    logic [XWDT-1:0] sa;
    logic [SW-1:0]   sum;
    sa          = {XWDT{1'b0}};
    sum         = {SW{1'b0}};
    set_ready_s = {NSET{1'b1}};
    set_acc_s   = {NSET{1'b0}};
    set_ovf_s   = {NSET{1'b0}};
    for (int i = 0; i < NSET; i++) begin
      sa  = set_addr[i*XWDT +: XWDT];
      sum = {{(SW-CNTW){1'b0}}, cnt_r[sa]};
      for (int k = 0; k < i; k++) begin
        if (set_valid[k] && (set_addr[k*XWDT +: XWDT] == sa)) begin
          sum = sum + SW'(1);
        end else begin
          sum = sum;
        end
      end
      if (in_range(sa)) begin
        set_ready_s[i] = (sum < CMAX);
      end else begin
        set_ready_s[i] = 1'b1;
      end
      set_acc_s[i] = set_valid[i] & set_ready_s[i] & in_range(sa);
      set_ovf_s[i] = set_valid[i] & ~set_ready_s[i];
    end
  end

  // Per-register next count: add accepted sets, then apply clears in port
  // order so a clear can consume a set arriving in the same cycle.
  always_comb begin : next_cnt_p
    logic [SW-1:0]   avail;
    logic [XWDT-1:0] ca;
    avail     = {SW{1'b0}};
    ca        = {XWDT{1'b0}};
    unf_evt_s = 1'b0;
    ovf_evt_s = 1'b0;
    for (int r = 0; r < XN; r++) begin
      avail = {{(SW-CNTW){1'b0}}, cnt_r[r]};
      for (int i = 0; i < NSET; i++) begin
        if (set_acc_s[i] && (set_addr[i*XWDT +: XWDT] == XWDT'(r))) begin
          avail = avail + SW'(1);
        end else begin
          avail = avail;
        end
      end
      for (int j = 0; j < NCLR; j++) begin
        ca = clr_addr[j*XWDT +: XWDT];
        if (clr_valid[j] && in_range(ca) && (ca == XWDT'(r))) begin
          if (avail != {SW{1'b0}}) begin
            avail = avail - SW'(1);
          end else begin
            unf_evt_s = 1'b1;
          end
        end else begin
          avail = avail;
        end
      end
      cnt_nxt_s[r] = avail[CNTW-1:0];
    end
    // Flush wins over everything this cycle and suppresses error reporting.
    if (flush) begin
      for (int r = 0; r < XN; r++) begin
        cnt_nxt_s[r] = {CNTW{1'b0}};
      end
      unf_evt_s = 1'b0;
      ovf_evt_s = 1'b0;
    end else begin
      ovf_evt_s = |set_ovf_s;
    end
  end

  // State: counters, the lock bitmap mirror, and the sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < XN; r++) begin
        cnt_r[r] <= {CNTW{1'b0}};
      end
      rlocks_r  <= {XN{1'b0}};
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      for (int r = 0; r < XN; r++) begin
        cnt_r[r]    <= cnt_nxt_s[r];
        rlocks_r[r] <= (cnt_nxt_s[r] != {CNTW{1'b0}});
      end
      err_ovf_r <= err_ovf_r | ovf_evt_s;
      err_unf_r <= err_unf_r | unf_evt_s;
    end
  end

  // Operand queries read only the registered lock state, never this cycle's traffic.
  always_comb begin : query_p
    logic [XWDT-1:0] qa;
    qa       = {XWDT{1'b0}};
    q_busy_s = {NQ{1'b0}};
    for (int p = 0; p < NQ; p++) begin
      qa = q_addr[p*XWDT +: XWDT];
      if (in_range(qa)) begin
        q_busy_s[p] = rlocks_r[qa];
      end else begin
        q_busy_s[p] = 1'b0;
      end
    end
  end

  assign set_ready = set_ready_s;
  assign q_busy    = q_busy_s;
  assign rlocks    = rlocks_r;
  assign err_ovf   = err_ovf_r;
  assign err_unf   = err_unf_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a driver applies directed and random
// traffic, predicts the visible outputs from an integer-count model and queues
// them; a monitor on the falling edge pops and compares.
module tb_reg_scoreboard;

  localparam int XWDT = 6;
  localparam int XN   = 64;
  localparam int NSET = 2;
  localparam int NCLR = 2;
  localparam int NQ   = 3;
  localparam int MAXC = 3;

  logic                 clk;
  logic                 rst;
  logic [NSET-1:0]      set_valid;
  logic [NSET*XWDT-1:0] set_addr;
  logic [NSET-1:0]      set_ready;
  logic [NCLR-1:0]      clr_valid;
  logic [NCLR*XWDT-1:0] clr_addr;
  logic                 flush;
  logic [NQ*XWDT-1:0]   q_addr;
  logic [NQ-1:0]        q_busy;
  logic [XN-1:0]        rlocks;
  logic                 err_ovf;
  logic                 err_unf;

  typedef struct {
    logic [NSET-1:0] sr;
    logic [NQ-1:0]   qb;
    logic [XN-1:0]   rl;
    logic            eo;
    logic            eu;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt [XN];
  logic m_eo;
  logic m_eu;
  int   cyc_n;
  int   checks;
  int   errs;

  reg_scoreboard #(.XWDT(XWDT), .XN(XN), .NSET(NSET), .NCLR(NCLR), .NQ(NQ), .CNTW(2)) dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_addr(set_addr), .set_ready(set_ready),
    .clr_valid(clr_valid), .clr_addr(clr_addr), .flush(flush),
    .q_addr(q_addr), .q_busy(q_busy), .rlocks(rlocks),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tracked(input int a);
    return (a != 0) && (a < XN);
  endfunction

  function automatic void check(input string nm, input int cyc, input logic [XN-1:0] got, input logic [XN-1:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, want);
    end
  endfunction

  // One cycle: apply inputs, predict outputs from the model, queue them, advance the model.
  task automatic step(input logic [1:0] sv, input int sa0, input int sa1,
                      input logic [1:0] cv, input int ca0, input int ca1,
                      input logic fl, input int q0, input int q1, input int q2,
                      input logic r);
    int   sa [NSET];
    int   ca [NCLR];
    int   qa [NQ];
    int   n;
    exp_t e;
    sa = '{sa0, sa1};
    ca = '{ca0, ca1};
    qa = '{q0, q1, q2};
    @(posedge clk);
    #1;
    rst       = r;
    set_valid = sv;
    set_addr  = {6'(sa1), 6'(sa0)};
    clr_valid = cv;
    clr_addr  = {6'(ca1), 6'(ca0)};
    flush     = fl;
    q_addr    = {6'(q2), 6'(q1), 6'(q0)};
    if (r) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_eo = 1'b0;
      m_eu = 1'b0;
    end
    for (int i = 0; i < NSET; i++) begin
      n = 0;
      for (int k = 0; k < i; k++) if (sv[k] && sa[k] == sa[i]) n++;
      e.sr[i] = tracked(sa[i]) ? ((m_cnt[sa[i]] + n) < MAXC) : 1'b1;
    end
    for (int p = 0; p < NQ; p++) e.qb[p] = tracked(qa[p]) ? (m_cnt[qa[p]] != 0) : 1'b0;
    for (int k = 0; k < XN; k++) e.rl[k] = (m_cnt[k] != 0);
    e.eo  = m_eo;
    e.eu  = m_eu;
    e.cyc = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
    if (!r) begin
      if (fl) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
      end else begin
        for (int i = 0; i < NSET; i++) begin
          if (sv[i] && tracked(sa[i])) begin
            if (e.sr[i]) m_cnt[sa[i]]++;
            else m_eo = 1'b1;
          end
        end
        for (int j = 0; j < NCLR; j++) begin
          if (cv[j] && tracked(ca[j])) begin
            if (m_cnt[ca[j]] > 0) m_cnt[ca[j]]--;
            else m_eu = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic int pick();
    return ($urandom_range(0, 99) < 80) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 63));
  endfunction

  // Monitor: every cycle the DUT presents a full output set; compare it with the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("set_ready", e.cyc, XN'(set_ready), XN'(e.sr));
      check("q_busy",    e.cyc, XN'(q_busy),    XN'(e.qb));
      check("rlocks",    e.cyc, rlocks,         e.rl);
      check("err_ovf",   e.cyc, XN'(err_ovf),   XN'(e.eo));
      check("err_unf",   e.cyc, XN'(err_unf),   XN'(e.eu));
    end
  end

  initial begin
    checks = 0; errs = 0; cyc_n = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_eo = 1'b0; m_eu = 1'b0;
    rst = 1'b1; set_valid = '0; set_addr = '0; clr_valid = '0; clr_addr = '0;
    flush = 1'b0; q_addr = '0;
    // reset state
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 5, 7, 9, 1'b1);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 5, 7, 9, 1'b0);
    // two sets to r5 in one cycle, then retire one at a time
    step(2'b11, 5, 5, 2'b00, 0, 0, 1'b0, 5, 7, 9, 1'b0);
    step(2'b00, 0, 0, 2'b01, 5, 0, 1'b0, 5, 7, 9, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 5, 7, 9, 1'b0);
    step(2'b00, 0, 0, 2'b10, 0, 5, 1'b0, 5, 7, 9, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 5, 7, 9, 1'b0);
    // saturate r7, fourth set is refused
    step(2'b01, 7, 0, 2'b00, 0, 0, 1'b0, 7, 5, 9, 1'b0);
    step(2'b10, 0, 7, 2'b00, 0, 0, 1'b0, 7, 5, 9, 1'b0);
    step(2'b01, 7, 0, 2'b00, 0, 0, 1'b0, 7, 5, 9, 1'b0);
    step(2'b01, 7, 0, 2'b00, 0, 0, 1'b0, 7, 5, 9, 1'b0);
    step(2'b00, 7, 0, 2'b00, 0, 0, 1'b0, 7, 5, 9, 1'b0);
    // set+clear r9 at zero nets out silently; lone clear underflows
    step(2'b01, 9, 0, 2'b01, 9, 0, 1'b0, 9, 7, 0, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 9, 7, 0, 1'b0);
    step(2'b00, 0, 0, 2'b10, 0, 9, 1'b0, 9, 7, 0, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 9, 7, 0, 1'b0);
    // register 0 is never locked
    step(2'b11, 0, 0, 2'b00, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    // reset mid-run with r7 locked and errors sticky
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 7, 0, 0, 1'b1);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 7, 0, 0, 1'b0);
    // lock r3/r4, raise an error, then flush alongside a set to r10
    step(2'b11, 3, 4, 2'b00, 0, 0, 1'b0, 3, 4, 10, 1'b0);
    step(2'b00, 0, 0, 2'b01, 12, 0, 1'b0, 3, 4, 10, 1'b0);
    step(2'b01, 10, 0, 2'b01, 20, 0, 1'b1, 3, 4, 10, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 3, 4, 10, 1'b0);
    // randomized traffic concentrated on a few registers
    for (int t = 0; t < 1500; t++) begin
      step(2'($urandom), pick(), pick(), 2'($urandom), pick(), pick(),
           ($urandom_range(0, 29) == 0), pick(), pick(), pick(),
           ($urandom_range(0, 149) == 0));
    end
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 1, 2, 3, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
